// File: rtl/exception_vector_sequencer_pkg.sv
// Shared select codes, vector addresses, cause and state encodings for the
// exception vector sequencer and the memory-address select mux.
package exception_vector_sequencer_pkg;

  localparam logic [2:0] SEL_PC     = 3'd0;
  localparam logic [2:0] SEL_ALUOUT = 3'd1;
  localparam logic [2:0] SEL_NOOP   = 3'd2;
  localparam logic [2:0] SEL_OVF    = 3'd3;
  localparam logic [2:0] SEL_DIV0   = 3'd4;
  localparam logic [2:0] SEL_ALURES = 3'd5;

  localparam logic [7:0] VEC_ADDR_NOOP = 8'd253;
  localparam logic [7:0] VEC_ADDR_OVF  = 8'd254;
  localparam logic [7:0] VEC_ADDR_DIV0 = 8'd255;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_NOOP = 2'd1,
    CAUSE_OVF  = 2'd2,
    CAUSE_DIV0 = 2'd3
  } cause_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    CAPTURE,
    COMMIT
  } state_t;

  function automatic logic [2:0] sel_code(input cause_t c);
    case (c)
      CAUSE_NOOP: sel_code = SEL_NOOP;
      CAUSE_OVF:  sel_code = SEL_OVF;
      CAUSE_DIV0: sel_code = SEL_DIV0;
      default:    sel_code = SEL_PC;
    endcase
  endfunction

endpackage

// File: rtl/exception_vector_sequencer_latency_counter.sv
// Memory-latency wait counter: clears on sequence entry, counts while enabled,
// and flags the last wait cycle.
module latency_counter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 3'd1;
    end
  end

  assign terminal = (count == 3'(MEM_LATENCY - 1));

endmodule

// File: rtl/exception_vector_sequencer.sv
// Fetches the exception vector byte through the address mux, then loads PC
// with the vector and EPC with the faulting PC while stalling main control.
module exception_vector_sequencer
  import exception_vector_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_noop,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] in_pc,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  src_add_mem,
  output logic        mem_wr,
  output logic        stall,
  output logic        epc_write,
  output logic [31:0] epc_value,
  output logic        pc_write,
  output logic [31:0] pc_value,
  output logic [1:0]  cause,
  output logic        exc_lost
);

  state_t      state;
  cause_t      cause_q;
  cause_t      next_cause;
  logic [31:0] pc_latched;
  logic        any_exc;
  logic        cnt_clear;
  logic        cnt_en;
  logic        cnt_done;
  logic        unused_rdata_hi;

  assign any_exc         = exc_noop | exc_overflow | exc_div0;
  assign cnt_clear       = (state == IDLE) && any_exc;
  assign cnt_en          = (state == SELECT);
  assign mem_wr          = 1'b0;
  assign cause           = cause_q;
  assign unused_rdata_hi = ^mem_rdata[31:8];

  always_comb begin
    next_cause = CAUSE_NONE;
    if (exc_div0)          next_cause = CAUSE_DIV0;
    else if (exc_overflow) next_cause = CAUSE_OVF;
    else if (exc_noop)     next_cause = CAUSE_NOOP;
  end

  latency_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cause_q     <= CAUSE_NONE;
      pc_latched  <= '0;
      src_add_mem <= SEL_PC;
      stall       <= 1'b0;
      epc_write   <= 1'b0;
      epc_value   <= '0;
      pc_write    <= 1'b0;
      pc_value    <= '0;
      exc_lost    <= 1'b0;
    end else begin
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      // The COMMIT cycle is deliberately excluded: an event there is taken from IDLE next.
      if (any_exc && (state == SELECT || state == CAPTURE)) exc_lost <= 1'b1;
      unique case (state)
        IDLE: begin
          if (any_exc) begin
            state       <= SELECT;
            cause_q     <= next_cause;
            pc_latched  <= in_pc;
            src_add_mem <= sel_code(next_cause);
            stall       <= 1'b1;
          end
        end
        SELECT: begin
          if (cnt_done) state <= CAPTURE;
        end
        CAPTURE: begin
          state       <= COMMIT;
          src_add_mem <= SEL_PC;
          pc_value    <= {24'd0, mem_rdata[7:0]};
          epc_value   <= pc_latched - EPC_OFFSET;
          pc_write    <= 1'b1;
          epc_write   <= 1'b1;
        end
        COMMIT: begin
          state <= IDLE;
          stall <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_vector_sequencer.sv
// Directed plus randomized bench for exception_vector_sequencer; two instances
// (MEM_LATENCY 2 and 1) share stimulus and are checked against a cycle model.
module tb_exception_vector_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_noop = 1'b0, exc_overflow = 1'b0, exc_div0 = 1'b0;
  logic [31:0] in_pc = '0, mem_rdata = '0;

  logic [1:0][2:0]  src;
  logic [1:0]       mwr, stl, epcw, pcw, lost;
  logic [1:0][31:0] epcv, pcv;
  logic [1:0][1:0]  cse;

  int tests = 0;
  int fails = 0;

  // Model state: k counts clock edges since the entry edge.
  int          lat[2] = '{2, 1};
  bit          m_busy[2];
  int          m_k[2];
  logic [1:0]  m_cause[2];
  logic [31:0] m_pc[2], m_pcv[2], m_epcv[2];
  bit          m_lost[2];

  always #5 clk = ~clk;

  exception_vector_sequencer #(.MEM_LATENCY(2), .EPC_OFFSET(32'd4)) dut0 (
    .clk(clk), .reset(reset), .exc_noop(exc_noop), .exc_overflow(exc_overflow),
    .exc_div0(exc_div0), .in_pc(in_pc), .mem_rdata(mem_rdata),
    .src_add_mem(src[0]), .mem_wr(mwr[0]), .stall(stl[0]), .epc_write(epcw[0]),
    .epc_value(epcv[0]), .pc_write(pcw[0]), .pc_value(pcv[0]), .cause(cse[0]),
    .exc_lost(lost[0]));

  exception_vector_sequencer #(.MEM_LATENCY(1), .EPC_OFFSET(32'd4)) dut1 (
    .clk(clk), .reset(reset), .exc_noop(exc_noop), .exc_overflow(exc_overflow),
    .exc_div0(exc_div0), .in_pc(in_pc), .mem_rdata(mem_rdata),
    .src_add_mem(src[1]), .mem_wr(mwr[1]), .stall(stl[1]), .epc_write(epcw[1]),
    .epc_value(epcv[1]), .pc_write(pcw[1]), .pc_value(pcv[1]), .cause(cse[1]),
    .exc_lost(lost[1]));

  function automatic logic [2:0] code_of(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b010;
      2'd2:    return 3'b011;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_k[i] = 0; m_cause[i] = 2'd0;
      m_pc[i] = '0; m_pcv[i] = '0; m_epcv[i] = '0; m_lost[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit ev;
    ev = exc_noop | exc_overflow | exc_div0;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i]) begin
        if (ev && m_k[i] <= lat[i] + 1) m_lost[i] = 1;
        if (m_k[i] == lat[i] + 1) begin
          m_pcv[i]  = {24'd0, mem_rdata[7:0]};
          m_epcv[i] = m_pc[i] - 32'd4;
        end
        if (m_k[i] == lat[i] + 2) m_busy[i] = 0;
        else m_k[i]++;
      end else if (ev) begin
        m_busy[i]  = 1;
        m_k[i]     = 1;
        m_pc[i]    = in_pc;
        m_cause[i] = exc_div0 ? 2'd3 : exc_overflow ? 2'd2 : 2'd1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      bit commit;
      commit = m_busy[i] && (m_k[i] == lat[i] + 2);
      chk("src_add_mem", i, 32'(src[i]), 32'((m_busy[i] && m_k[i] <= lat[i] + 1) ? code_of(m_cause[i]) : 3'b000));
      chk("stall",       i, 32'(stl[i]),  32'(m_busy[i]));
      chk("pc_write",    i, 32'(pcw[i]),  32'(commit));
      chk("epc_write",   i, 32'(epcw[i]), 32'(commit));
      chk("pc_value",    i, pcv[i],       m_pcv[i]);
      chk("epc_value",   i, epcv[i],      m_epcv[i]);
      chk("cause",       i, 32'(cse[i]),  32'(m_cause[i]));
      chk("exc_lost",    i, 32'(lost[i]), 32'(m_lost[i]));
      chk("mem_wr",      i, 32'(mwr[i]),  32'd0);
    end
  endtask

  // Check the cycle now ending, then advance through one rising edge.
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_ev(input logic n, input logic o, input logic d);
    exc_noop = n; exc_overflow = o; exc_div0 = d;
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    set_ev(1, 1, 1);
    @(negedge clk);
    repeat (2) cycle();
    set_ev(0, 0, 0);
    reset = 1'b1;
    repeat (3) cycle();

    // Overflow with the reference example values.
    in_pc = 32'h0000_0040; mem_rdata = 32'h0000_00A5;
    set_ev(0, 1, 0);
    cycle();
    set_ev(0, 0, 0);
    repeat (6) cycle();
    chk("ovf_pc_value",  0, pcv[0],  32'h0000_00A5);
    chk("ovf_epc_value", 0, epcv[0], 32'h0000_003C);
    chk("ovf_cause",     0, 32'(cse[0]), 32'd2);

    // Simultaneous events resolve to div0.
    in_pc = 32'h0000_1000; mem_rdata = 32'h1234_56FF;
    set_ev(1, 1, 1);
    cycle();
    set_ev(0, 0, 0);
    repeat (6) cycle();

    // Noop pulse while busy is lost; a later noop is taken.
    in_pc = 32'h0000_2000; mem_rdata = 32'h0000_00C3;
    set_ev(0, 0, 1);
    cycle();
    set_ev(1, 0, 0);
    cycle();
    set_ev(0, 0, 0);
    repeat (5) cycle();
    set_ev(1, 0, 0); mem_rdata = 32'h0000_00FD;
    cycle();
    set_ev(0, 0, 0);
    repeat (6) cycle();

    // Reset during CAPTURE of the latency-2 instance aborts the sequence.
    in_pc = 32'h0000_3000; mem_rdata = 32'h0000_0011;
    set_ev(0, 1, 0);
    cycle();
    set_ev(0, 0, 0);
    repeat (2) cycle();
    chk("pre_reset_capture_src", 0, 32'(src[0]), 32'd3);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cycle();

    // Latency-1 instance: wrap-around EPC and low-byte-only vector.
    in_pc = 32'h0; mem_rdata = 32'hFFFF_FF07;
    set_ev(1, 0, 0);
    cycle();
    set_ev(0, 0, 0);
    repeat (2) cycle();
    chk("lat1_pc_write",  1, 32'(pcw[1]), 32'd1);
    chk("lat1_pc_value",  1, pcv[1],      32'd7);
    chk("lat1_epc_value", 1, epcv[1],     32'hFFFF_FFFC);
    repeat (4) cycle();

    // Event held through COMMIT re-triggers from IDLE.
    in_pc = 32'h0000_4444; mem_rdata = 32'h0000_0042;
    set_ev(0, 1, 0);
    repeat (10) cycle();
    set_ev(0, 0, 0);
    repeat (6) cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      set_ev(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      in_pc = $urandom;
      mem_rdata = $urandom;
      cycle();
    end
    set_ev(0, 0, 0);
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
